imem_loader_ram: RTL and testbench

Parametrised successor to the instruction memory. It provides a dual-port instruction RAM with a registered fetch port and stall-hold for the pipeline IF stage, plus a valid/ready streaming loader port with an auto-incrementing write pointer. After reset, a hardware init sequence fills the whole array with the NOP word before fetch is enabled. It sits between the PC/IF stage and the external program loader.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_ram_1w1r.sv | 37 +++
 rtl/imem_loader_ram.sv | 148 ++++++++++++++
 tb/tb_imem_loader_ram.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state type, defaults and width helper for the instruction RAM
package imem_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0020;

  // ld_count has to represent DEPTH itself, so it is one bit wider than an address
  function automatic int ld_count_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/imem_ram_1w1r.sv
// rtl/imem_ram_1w1r.sv - word array with one write port and one registered, write-first read port
module imem_ram_1w1r #(
  parameter int              DATA_W  = 32,
  parameter int              ADDR_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // The read register only moves on a read enable, so the last word stays visible otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= RST_VAL;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader_ram.sv
// rtl/imem_loader_ram.sv - instruction RAM with NOP init sequence, stall-hold fetch and streaming loader
module imem_loader_ram
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            rst1,
  input  logic                            f_req,
  input  logic [ADDR_W-1:0]               f_addr,
  input  logic                            f_stall,
  output logic                            f_ready,
  output logic [DATA_W-1:0]               f_data,
  output logic                            f_valid,
  input  logic                            ld_start,
  input  logic [ADDR_W-1:0]               ld_base,
  input  logic                            ld_valid,
  input  logic [DATA_W-1:0]               ld_data,
  input  logic                            ld_last,
  output logic                            ld_ready,
  output logic                            ld_done,
  output logic [ld_count_w(ADDR_W)-1:0]   ld_count,
  output logic                            busy
);

  localparam int CNT_W = ld_count_w(ADDR_W);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  ld_count_q, ld_count_d;
  logic              ld_done_q, ld_done_d;
  logic              f_valid_q, f_valid_d;

  logic              ld_accept;
  logic              ld_end;
  logic              f_accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign ld_accept = (state_q == ST_LOAD) && ld_valid;
  // A burst ends on its flagged last word or once the whole array has been written
  assign ld_end    = ld_accept && (ld_last || (ld_count_q == CNT_W'(DEPTH - 1)));
  assign f_accept  = f_req && f_ready;

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (init_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      ST_RUN:  if (ld_start) state_d = ST_LOAD;
      ST_LOAD: if (ld_end) state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q;
    ram_wdata = ld_data;
    ld_ready  = 1'b0;
    f_ready   = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = init_ptr_q;
        ram_wdata = NOP_WORD;
      end
      ST_RUN: begin
        f_ready = !f_stall;
        busy    = 1'b0;
      end
      ST_LOAD: begin
        ram_we   = ld_valid;
        ld_ready = 1'b1;
        f_ready  = !f_stall;
      end
      default: ;
    endcase
  end

  always_comb begin
    init_ptr_d = init_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ld_count_d = ld_count_q;
    ld_done_d  = ld_end;
    f_valid_d  = f_stall ? f_valid_q : (f_req && (state_q != ST_INIT));
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
    end
    if ((state_q == ST_RUN) && ld_start) begin
      wr_ptr_d   = ld_base;
      ld_count_d = '0;
    end
    if (ld_accept) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      ld_count_d = ld_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      init_ptr_q <= '0;
      wr_ptr_q   <= '0;
      ld_count_q <= '0;
      ld_done_q  <= 1'b0;
      f_valid_q  <= 1'b0;
    end else begin
      init_ptr_q <= init_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ld_count_q <= ld_count_d;
      ld_done_q  <= ld_done_d;
      f_valid_q  <= f_valid_d;
    end
  end

  imem_ram_1w1r #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RST_VAL (NOP_WORD)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst1),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (f_accept),
    .raddr_i (f_addr),
    .rdata_o (f_data)
  );

  assign f_valid  = f_valid_q;
  assign ld_done  = ld_done_q;
  assign ld_count = ld_count_q;

endmodule

// File: tb/tb_imem_loader_ram.sv
// tb/tb_imem_loader_ram.sv - self-checking bench for imem_loader_ram against a memory-array reference model
module tb_imem_loader_ram;

  localparam int          DW     = 32;
  localparam int          AW     = 8;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] NOP    = 32'h0000_0020;
  localparam int          M_INIT = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_LOAD = 2;

  logic          clk      = 1'b0;
  logic          rst1     = 1'b1;
  logic          f_req    = 1'b0;
  logic [AW-1:0] f_addr   = '0;
  logic          f_stall  = 1'b0;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_base  = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data  = '0;
  logic          ld_last  = 1'b0;
  logic          f_ready, f_valid, ld_ready, ld_done, busy;
  logic [DW-1:0] f_data;
  logic [AW:0]   ld_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] burst [DEPTH];
  int            m_mode, m_left, m_wp, m_cnt;
  logic [DW-1:0] m_fdata;
  bit            m_fvalid, m_done;

  imem_loader_ram dut (
    .clk      (clk),
    .rst1     (rst1),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_stall  (f_stall),
    .f_ready  (f_ready),
    .f_data   (f_data),
    .f_valid  (f_valid),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_count (ld_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: combinational outputs checked before the edge, model advanced, registers checked after
  task automatic step();
    bit fire;
    #1;
    check("f_ready", f_ready, (m_mode != M_INIT) && !f_stall);
    check("ld_ready", ld_ready, m_mode == M_LOAD);
    check("busy", busy, m_mode != M_RUN);
    fire   = f_req && !f_stall && (m_mode != M_INIT);
    m_done = 1'b0;
    case (m_mode)
      M_INIT: begin
        m_left--;
        if (m_left == 0) m_mode = M_RUN;
      end
      M_RUN: if (ld_start) begin
        m_mode = M_LOAD;
        m_wp   = int'(ld_base);
        m_cnt  = 0;
      end
      default: if (ld_valid) begin
        m_mem[m_wp] = ld_data;
        m_wp        = (m_wp + 1) % DEPTH;
        m_cnt++;
        if (ld_last || m_cnt == DEPTH) begin
          m_mode = M_RUN;
          m_done = 1'b1;
        end
      end
    endcase
    if (!f_stall) begin
      m_fvalid = fire;
      if (fire) m_fdata = m_mem[int'(f_addr)];
    end
    @(posedge clk);
    #1;
    check("f_data", f_data, m_fdata);
    check("f_valid", f_valid, m_fvalid);
    check("ld_done", ld_done, m_done);
    check("ld_count", ld_count, m_cnt);
    if (ld_done) n_done++;
  endtask

  task automatic do_reset(input int hold);
    rst1 = 1'b0;
    f_req = 1'b0; f_stall = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_mode = M_INIT; m_left = DEPTH; m_wp = 0; m_cnt = 0;
    m_fdata = NOP; m_fvalid = 1'b0; m_done = 1'b0;
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_f_ready", f_ready, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_ld_done", ld_done, 1'b0);
    check("rst_f_valid", f_valid, 1'b0);
    check("rst_f_data", f_data, NOP);
    check("rst_ld_count", ld_count, 0);
    repeat (hold) @(posedge clk);
    #1;
    rst1 = 1'b1;
  endtask

  task automatic run_load(input logic [AW-1:0] base, input int n, input bit use_last, input int abort_at);
    ld_start = 1'b1; ld_base = base;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        do_reset(1);
        return;
      end
      while ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        step();
      end
      ld_valid = 1'b1; ld_data = burst[i]; ld_last = use_last && (i == n - 1);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    step();
  endtask

  task automatic fetch(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    f_req = 1'b1; f_addr = addr;
    step();
    f_req = 1'b0;
    check("fetch_data", f_data, exp);
    check("fetch_valid", f_valid, 1'b1);
  endtask

  initial begin
    int d0;
    logic [AW-1:0] b;
    @(posedge clk);
    #1;
    do_reset(2);
    repeat (DEPTH) step();
    check("ready_after_init", f_ready, 1'b1);
    fetch(8'h7F, NOP);

    burst[0] = 32'hA0; burst[1] = 32'hB1; burst[2] = 32'hC2;
    d0 = n_done;
    run_load(8'h10, 3, 1'b1, -1);
    step();
    check("burst_count", ld_count, 3);
    check("burst_done_pulses", n_done - d0, 1);
    fetch(8'h10, 32'hA0);
    fetch(8'h11, 32'hB1);
    fetch(8'h12, 32'hC2);
    fetch(8'h13, NOP);

    burst[0] = 32'h11; burst[1] = 32'h22; burst[2] = 32'h33; burst[3] = 32'h44;
    run_load(8'hFE, 4, 1'b1, -1);
    check("wrap_count", ld_count, 4);
    fetch(8'hFE, 32'h11);
    fetch(8'hFF, 32'h22);
    fetch(8'h00, 32'h33);
    fetch(8'h01, 32'h44);

    ld_start = 1'b1; ld_base = 8'h20;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hDEADBEEF; ld_last = 1'b1;
    f_req = 1'b1; f_addr = 8'h20;
    step();
    ld_valid = 1'b0; ld_last = 1'b0; f_req = 1'b0;
    check("collision_data", f_data, 32'hDEADBEEF);

    fetch(8'h10, 32'hA0);
    f_req = 1'b1; f_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_addr = AW'($urandom);
      #1;
      check("stall_ready", f_ready, 1'b0);
      step();
      check("stall_data", f_data, 32'hA0);
      check("stall_valid", f_valid, 1'b1);
    end
    f_stall = 1'b0; f_req = 1'b0;

    for (int i = 0; i < 5; i++) burst[i] = $urandom;
    d0 = n_done;
    run_load(8'h40, 5, 1'b1, 2);
    for (int i = 0; i < DEPTH; i++) begin
      ld_start = (i < 100);
      step();
    end
    ld_start = 1'b0;
    fetch(8'h40, NOP);
    fetch(8'h41, NOP);
    check("abort_no_done", n_done - d0, 0);

    for (int i = 0; i < DEPTH; i++) burst[i] = $urandom;
    b = AW'($urandom);
    run_load(b, DEPTH, 1'b0, -1);
    check("full_count", ld_count, DEPTH);
    fetch(b, burst[0]);
    fetch(b - 8'd1, burst[DEPTH-1]);

    for (int i = 0; i < 400; i++) begin
      ld_start = ($urandom_range(0, 7) == 0);
      ld_base  = AW'($urandom);
      ld_valid = $urandom_range(0, 1);
      ld_data  = $urandom;
      ld_last  = ($urandom_range(0, 5) == 0);
      f_req    = $urandom_range(0, 1);
      f_stall  = ($urandom_range(0, 3) == 0);
      f_addr   = AW'($urandom);
      step();
    end
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; f_req = 1'b0; f_stall = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
